// File: rtl/controle_elevador.sv
// Three-floor elevator controller: latches merged floor calls, runs a SCAN policy
// between floors 0..2 and times travel and door. Macro ELEVADOR_REABRE_EN enables door reopen.
`timescale 1ns/1ps
module controle_elevador #(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A0,
  input  logic       A1,
  input  logic       A2,
  output logic [1:0] andar,
  output logic       subindo,
  output logic       descendo,
  output logic       porta_aberta,
  output logic [2:0] pendente,
  output logic [2:0] atendido,
  output logic [1:0] estado
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVING    = 2'd1;
  localparam logic [1:0] DOOR_OPEN = 2'd2;
  localparam logic       UP        = 1'b0;
  localparam logic       DOWN      = 1'b1;

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

  logic [1:0]    state, state_n;
  logic          dir, dir_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0]    andar_n;
  logic [2:0]    pend_n, aten_n;
  logic [2:0]    calls, here, stop_at, above, below;
  logic          decide, reopen, eff_dir, ahead, behind;

  always_comb begin
    calls   = {A2, A1, A0};
    here    = 3'b001 << andar;
    state_n = state;
    andar_n = andar;
    dir_n   = dir;
    timer_n = timer;
    aten_n  = 3'b000;
    decide  = 1'b0;
`ifdef ELEVADOR_REABRE_EN
    reopen  = (state == DOOR_OPEN) && |(calls & here);
`else
    reopen  = 1'b0;
`endif
    // While the door is open the call of the current floor never latches.
    pend_n  = pendente | (calls & ((state == DOOR_OPEN) ? ~here : 3'b111));

    case (state)
      IDLE: decide = 1'b1;
      MOVING: begin
        if (timer == TRAVEL_LAST) begin
          andar_n = (dir == UP) ? andar + 2'd1 : andar - 2'd1;
          timer_n = '0;
          decide  = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (reopen) begin
          timer_n = '0;
          aten_n  = here;
        end else if (timer == DOOR_LAST) begin
          decide = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Decision is taken for the floor the car occupies after this edge.
    stop_at = 3'b001 << andar_n;
    above   = 3'b000;
    below   = 3'b000;
    eff_dir = dir;
    case (andar_n)
      2'd0: begin above = 3'b110; below = 3'b000; eff_dir = UP;   end
      2'd1: begin above = 3'b100; below = 3'b001; eff_dir = dir;  end
      default: begin above = 3'b000; below = 3'b011; eff_dir = DOWN; end
    endcase
    ahead  = (eff_dir == UP) ? |(pendente & above) : |(pendente & below);
    behind = (eff_dir == UP) ? |(pendente & below) : |(pendente & above);

    if (decide) begin
      if (|(pendente & stop_at)) begin
        state_n = DOOR_OPEN;
        timer_n = '0;
        pend_n  = pend_n & ~stop_at;
        aten_n  = stop_at;
      end else if (ahead) begin
        state_n = MOVING;
        dir_n   = eff_dir;
        timer_n = '0;
      end else if (behind) begin
        state_n = MOVING;
        dir_n   = ~eff_dir;
        timer_n = '0;
      end else begin
        state_n = IDLE;
        timer_n = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dir          <= UP;
      timer        <= '0;
      andar        <= 2'd0;
      pendente     <= 3'b000;
      atendido     <= 3'b000;
      subindo      <= 1'b0;
      descendo     <= 1'b0;
      porta_aberta <= 1'b0;
    end else begin
      state        <= state_n;
      dir          <= dir_n;
      timer        <= timer_n;
      andar        <= andar_n;
      pendente     <= pend_n;
      atendido     <= aten_n;
      subindo      <= (state_n == MOVING) && (dir_n == UP);
      descendo     <= (state_n == MOVING) && (dir_n == DOWN);
      porta_aberta <= (state_n == DOOR_OPEN);
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_controle_elevador.sv
// Bench for controle_elevador: reset-sequence vector table, directed SCAN/hold/arrival
// sequences with a served-floor scoreboard, and random calls against a floor-level model.
`timescale 1ns/1ps
module tb_controle_elevador;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;
`ifdef ELEVADOR_REABRE_EN
  localparam int HELD_PULSES = 15;
`else
  localparam int HELD_PULSES = 3;
`endif

  logic       clk, rst_n, A0, A1, A2;
  logic [1:0] andar, estado;
  logic       subindo, descendo, porta_aberta;
  logic [2:0] pendente, atendido;

  controle_elevador #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk(clk), .rst_n(rst_n), .A0(A0), .A1(A1), .A2(A2),
    .andar(andar), .subindo(subindo), .descendo(descendo),
    .porta_aberta(porta_aberta), .pendente(pendente), .atendido(atendido),
    .estado(estado)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_MOVE, M_DOOR} mmode_t;
  mmode_t   m_mode;
  int       m_floor, m_dir, m_elapsed;
  bit [2:0] m_calls, m_aten;

  function automatic bit any_toward(input int fl, input int d, input bit [2:0] c);
    for (int f = fl + d; f >= 0 && f <= 2; f += d)
      if (c[f]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_dir = 1; m_elapsed = 0;
    m_calls = 3'b000; m_aten = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] a);
    bit [2:0] seen, nxt;
    bit       decide, reopen;
    int       want;
    seen = m_calls; nxt = m_calls; decide = 0; reopen = 0;
    for (int i = 0; i < 3; i++)
      if (a[i] && !(m_mode == M_DOOR && i == m_floor)) nxt[i] = 1'b1;
    m_aten = 3'b000;
    case (m_mode)
      M_IDLE: decide = 1;
      M_MOVE: begin
        if (m_elapsed == TRAVEL - 1) begin
          m_floor += m_dir; m_elapsed = 0; decide = 1;
        end else m_elapsed++;
      end
      default: begin
`ifdef ELEVADOR_REABRE_EN
        reopen = a[m_floor];
`endif
        if (reopen) begin
          m_elapsed = 0; m_aten[m_floor] = 1'b1;
        end else if (m_elapsed == DOOR - 1) decide = 1;
        else m_elapsed++;
      end
    endcase
    if (decide) begin
      if (seen[m_floor]) begin
        m_mode = M_DOOR; m_elapsed = 0; nxt[m_floor] = 1'b0; m_aten[m_floor] = 1'b1;
      end else begin
        want = (m_floor == 0) ? 1 : (m_floor == 2) ? -1 : m_dir;
        m_elapsed = 0;
        if (any_toward(m_floor, want, seen)) begin
          m_mode = M_MOVE; m_dir = want;
        end else if (any_toward(m_floor, -want, seen)) begin
          m_mode = M_MOVE; m_dir = -want;
        end else m_mode = M_IDLE;
      end
    end
    m_calls = nxt;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_andar"}, andar, m_floor);
    check({tag, "_pendente"}, pendente, m_calls);
    check({tag, "_atendido"}, atendido, m_aten);
    check({tag, "_porta"}, porta_aberta, (m_mode == M_DOOR) ? 1 : 0);
    check({tag, "_subindo"}, subindo, (m_mode == M_MOVE && m_dir > 0) ? 1 : 0);
    check({tag, "_descendo"}, descendo, (m_mode == M_MOVE && m_dir < 0) ? 1 : 0);
  endtask

  // ---------------- scoreboard of served floors ----------------
  logic [1:0] exp_q[$];
  bit         sb_on = 0;
  int         held_count = 0;

  task automatic sb_check();
    logic [1:0] e;
    for (int i = 0; i < 3; i++) begin
      if (atendido[i]) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_service", i, -1);
        end else begin
          e = exp_q.pop_front();
          check("sb_service_order", i, e);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drives inputs, advances one edge, returns at the next negedge.
  task automatic step(input logic [2:0] a);
    {A2, A1, A0} = a;
    @(posedge clk);
    model_step(a);
    @(negedge clk);
    if (sb_on) sb_check();
  endtask

  task automatic run(input logic [2:0] a, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      step(a);
      compare_model(tag);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] a;
    logic [1:0] andar;
    logic [2:0] pend;
    logic [2:0] aten;
    logic       porta, sub, desc;
  } vec_t;
  vec_t tbl[18];

  initial begin
    // A0 pulse served in place, then A2 pulse carried through floor 1 to floor 2.
    tbl[0]  = '{3'b001, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'b000, 2'd0, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{3'b000, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{3'b000, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{3'b000, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'b100, 2'd0, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0};
    for (int i = 6; i < 10; i++)  tbl[i] = '{3'b000, 2'd0, 3'b100, 3'b000, 1'b0, 1'b1, 1'b0};
    for (int i = 10; i < 14; i++) tbl[i] = '{3'b000, 2'd1, 3'b100, 3'b000, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{3'b000, 2'd2, 3'b000, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{3'b000, 2'd2, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{3'b000, 2'd2, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{3'b000, 2'd2, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; {A2, A1, A0} = 3'b000;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_andar", andar, 0);
    check("reset_pendente", pendente, 0);
    check("reset_atendido", atendido, 0);
    check("reset_porta", porta_aberta, 0);
    check("reset_subindo", subindo, 0);
    check("reset_descendo", descendo, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].a);
      check($sformatf("tbl%0d_andar", i), andar, tbl[i].andar);
      check($sformatf("tbl%0d_pendente", i), pendente, tbl[i].pend);
      check($sformatf("tbl%0d_atendido", i), atendido, tbl[i].aten);
      check($sformatf("tbl%0d_porta", i), porta_aberta, tbl[i].porta);
      check($sformatf("tbl%0d_subindo", i), subindo, tbl[i].sub);
      check($sformatf("tbl%0d_descendo", i), descendo, tbl[i].desc);
    end

    // Held A1 from floor 2: car descends to 1, then the held call reopens the door.
    for (int k = 0; k < 20; k++) begin
      step(3'b010);
      compare_model("held");
      if (atendido[1]) held_count++;
    end
    check("held_a1_pulses", held_count, HELD_PULSES);
    run(3'b000, 10, "held_release");

    // SCAN: go to floor 0, then head up for 2 and call 0 while passing floor 1.
    sb_on = 1;
    exp_q.push_back(2'd0);
    step(3'b001); compare_model("scan_pre");
    run(3'b000, 11, "scan_pre");
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    step(3'b100); compare_model("scan");
    run(3'b000, 5, "scan");
    check("scan_floor1_moving_up", andar * 2 + subindo, 3);
    step(3'b001); compare_model("scan");
    run(3'b000, 23, "scan");
    check("scan_drained", exp_q.size(), 0);

    // New call at a floor on the way: stop at 1, then continue to 2.
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    step(3'b100); compare_model("arrive");
    step(3'b000); compare_model("arrive");
    step(3'b010); compare_model("arrive");
    run(3'b000, 22, "arrive");
    check("arrive_drained", exp_q.size(), 0);
    sb_on = 0;

    // Asynchronous reset while descending from floor 2 through floor 1.
    step(3'b001); compare_model("rst_mid");
    run(3'b000, 6, "rst_mid");
    check("rst_mid_was_moving", descendo, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_andar", andar, 0);
    check("async_rst_pendente", pendente, 0);
    check("async_rst_atendido", atendido, 0);
    check("async_rst_porta", porta_aberta, 0);
    check("async_rst_subindo", subindo, 0);
    check("async_rst_descendo", descendo, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random sparse calls against the model.
    for (int k = 0; k < 600; k++) begin
      logic [2:0] a;
      for (int b = 0; b < 3; b++) a[b] = ($urandom_range(0, 7) == 0);
      step(a);
      compare_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
